// File: rtl/m_control_pkg.sv
// Shared definitions for the M-extension unit: mux encodings/widths, funct3 codes, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a. Divide support is controlled by the M_DIV_EN macro in the users of this package.
package m_control_pkg;

    localparam int MUX_R_LENGTH = 3;
    localparam int MUX_D_LENGTH = 2;
    localparam int MUX_Z_LENGTH = 2;

    // Remainder register select
    localparam logic [MUX_R_LENGTH-1:0] MUX_R_KEEP       = 3'd0;
    localparam logic [MUX_R_LENGTH-1:0] MUX_R_A          = 3'd1;
    localparam logic [MUX_R_LENGTH-1:0] MUX_R_A_NEG      = 3'd2;
    localparam logic [MUX_R_LENGTH-1:0] MUX_R_SUB_KEEP   = 3'd3;
    localparam logic [MUX_R_LENGTH-1:0] MUX_R_MULT_LOWER = 3'd4;

    // Divisor register select
    localparam logic [MUX_D_LENGTH-1:0] MUX_D_KEEP  = 2'd0;
    localparam logic [MUX_D_LENGTH-1:0] MUX_D_B     = 2'd1;
    localparam logic [MUX_D_LENGTH-1:0] MUX_D_B_NEG = 2'd2;
    localparam logic [MUX_D_LENGTH-1:0] MUX_D_SHR   = 2'd3;

    // Quotient register select
    localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_KEEP       = 2'd0;
    localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_ZERO       = 2'd1;
    localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_SHL_ADD    = 2'd2;
    localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_MULT_UPPER = 2'd3;

    // RV32M funct3 codes
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_LOAD = 3'd2,
        ST_ITER = 3'd3,
        ST_DONE = 3'd4
    } m_state_e;

    // DIV and REM are the signed divide ops; their funct3 LSB is 0
    function automatic logic f3_is_signed_div(input logic [2:0] f3);
        return f3[2] && !f3[0];
    endfunction

endpackage

// File: rtl/m_control_iter_counter.sv
// Divide iteration counter: parallel load, decrement to zero and hold, zero flag.
// Latency: load/decrement visible the cycle after the request; zero flag is combinational from the count.
// Backpressure: none; decrement requests at zero are ignored.
module m_iter_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    // next count: load wins over decrement, saturate at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // count register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/m_control.sv
// M-extension sequencer: drives R/D/Z mux selects for one-step multiply or restoring divide (macro M_DIV_EN).
// Latency: multiply 2 cycles start->done; divide ITER+2; without M_DIV_EN a divide op ends in 1 with illegal.
// Backpressure: ready only in IDLE; start seen while busy or in DONE is dropped, not queued.
module m_control
    import m_control_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [2:0]              funct3,
    input  logic                    rs1_sign,
    input  logic                    rs2_sign,
    input  logic                    rs2_zero,
    input  logic                    sub_neg,
    output logic [MUX_R_LENGTH-1:0] mux_R,
    output logic [MUX_D_LENGTH-1:0] mux_D,
    output logic [MUX_Z_LENGTH-1:0] mux_Z,
    output logic                    mult_signed_a,
    output logic                    mult_signed_b,
    output logic                    ready,
    output logic                    busy,
    output logic                    done,
    output logic                    res_sel,
    output logic                    res_neg,
    output logic                    illegal
);

    m_state_e   state_q, state_d;
    logic [2:0] op_q, op_d;

`ifdef M_DIV_EN
    localparam int CNT_W = $clog2(ITER);

    logic rs1_sign_q, rs1_sign_d;
    logic rs2_sign_q, rs2_sign_d;
    logic rs2_zero_q, rs2_zero_d;
    logic cnt_zero;
    logic div_signed;

    assign div_signed = f3_is_signed_div(op_q);

    m_iter_counter #(.W(CNT_W)) u_iter_counter (
        .clk      (clk),
        .resetn   (resetn),
        .load     (state_q == ST_LOAD),
        .dec      (state_q == ST_ITER),
        .load_val (CNT_W'(ITER - 1)),
        .zero     (cnt_zero)
    );
`else
    // divide datapath feedback and operand signs have no consumer in a multiply-only build
    logic unused_div;
    assign unused_div = ^{sub_neg, rs1_sign, rs2_sign, rs2_zero, ITER[0]};
`endif

    // state and captured-op registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
`ifdef M_DIV_EN
            rs1_sign_q <= 1'b0;
            rs2_sign_q <= 1'b0;
            rs2_zero_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
`ifdef M_DIV_EN
            rs1_sign_q <= rs1_sign_d;
            rs2_sign_q <= rs2_sign_d;
            rs2_zero_q <= rs2_zero_d;
`endif
        end
    end

    // next state; op fields are captured only when a start is accepted in IDLE
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
`ifdef M_DIV_EN
        rs1_sign_d = rs1_sign_q;
        rs2_sign_d = rs2_sign_q;
        rs2_zero_d = rs2_zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = funct3;
`ifdef M_DIV_EN
                    rs1_sign_d = rs1_sign;
                    rs2_sign_d = rs2_sign;
                    rs2_zero_d = rs2_zero;
                    state_d    = funct3[2] ? ST_LOAD : ST_MUL;
`else
                    state_d    = funct3[2] ? ST_DONE : ST_MUL;
`endif
                end
            end
            ST_MUL:  state_d = ST_DONE;
`ifdef M_DIV_EN
            ST_LOAD: state_d = ST_ITER;
            ST_ITER: state_d = cnt_zero ? ST_DONE : ST_ITER;
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from state and the captured op
    always_comb begin
        mux_R         = MUX_R_KEEP;
        mux_D         = MUX_D_KEEP;
        mux_Z         = MUX_Z_KEEP;
        mult_signed_a = 1'b0;
        mult_signed_b = 1'b0;
        ready         = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        illegal       = 1'b0;
        res_sel       = 1'b0;
        res_neg       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            ST_MUL: begin
                mux_R         = MUX_R_MULT_LOWER;
                mux_Z         = MUX_Z_MULT_UPPER;
                mult_signed_a = (op_q == F3_MULH) || (op_q == F3_MULHSU);
                mult_signed_b = (op_q == F3_MULH);
            end
`ifdef M_DIV_EN
            ST_LOAD: begin
                mux_Z = MUX_Z_ZERO;
                mux_R = (div_signed && rs1_sign_q) ? MUX_R_A_NEG : MUX_R_A;
                mux_D = (div_signed && rs2_sign_q) ? MUX_D_B_NEG : MUX_D_B;
            end
            ST_ITER: begin
                mux_R = MUX_R_SUB_KEEP;
                mux_Z = MUX_Z_SHL_ADD;
                mux_D = MUX_D_SHR;
            end
`endif
            ST_DONE: begin
                done = 1'b1;
`ifndef M_DIV_EN
                illegal = op_q[2];
`endif
            end
            default: ;
        endcase
        // result steering holds from the first working state through DONE
        if (state_q != ST_IDLE) begin
            if (!op_q[2]) begin
                res_sel = (op_q != F3_MUL);
            end
`ifdef M_DIV_EN
            else begin
                res_sel = !op_q[1];
                // divide-by-zero quotient is already all-ones, so it must not be negated
                res_neg = op_q[1] ? (div_signed && rs1_sign_q)
                                  : (div_signed && (rs1_sign_q ^ rs2_sign_q) && !rs2_zero_q);
            end
`endif
        end
    end

endmodule

// File: tb/tb_m_control.sv
// Bench for m_control: small R/D/Z datapath driven by the mux selects, results vs RV32M arithmetic.
// Latency: checks exact start->done cycle counts for multiply, divide and (without M_DIV_EN) illegal ops.
// Backpressure: pokes start while busy and checks it is ignored; issues back-to-back ops after done.
module tb_m_control;
    import m_control_pkg::*;

    localparam int ITER = 32;
`ifdef M_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic                    clk;
    logic                    resetn;
    logic                    start;
    logic [2:0]              funct3;
    logic                    rs1_sign, rs2_sign, rs2_zero, sub_neg;
    logic [MUX_R_LENGTH-1:0] mux_R;
    logic [MUX_D_LENGTH-1:0] mux_D;
    logic [MUX_Z_LENGTH-1:0] mux_Z;
    logic                    mult_signed_a, mult_signed_b;
    logic                    ready, busy, done, res_sel, res_neg, illegal;

    logic [31:0] a_in, b_in;
    logic [63:0] R, D, prod;
    logic [31:0] Z;

    int n_tests = 0;
    int n_fail  = 0;

    m_control #(.ITER(ITER)) dut (
        .clk(clk), .resetn(resetn), .start(start), .funct3(funct3),
        .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .rs2_zero(rs2_zero), .sub_neg(sub_neg),
        .mux_R(mux_R), .mux_D(mux_D), .mux_Z(mux_Z),
        .mult_signed_a(mult_signed_a), .mult_signed_b(mult_signed_b),
        .ready(ready), .busy(busy), .done(done), .res_sel(res_sel),
        .res_neg(res_neg), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Datapath: 64-bit R and D so the divisor can start shifted left by 31
    assign rs1_sign = a_in[31];
    assign rs2_sign = b_in[31];
    assign rs2_zero = (b_in == 32'd0);
    assign sub_neg  = (R < D);
    always_comb prod = {{32{mult_signed_a & a_in[31]}}, a_in} * {{32{mult_signed_b & b_in[31]}}, b_in};

    always @(posedge clk) begin
        case (mux_R)
            MUX_R_A:          R <= {32'd0, a_in};
            MUX_R_A_NEG:      R <= {32'd0, -a_in};
            MUX_R_SUB_KEEP:   if (!sub_neg) R <= R - D;
            MUX_R_MULT_LOWER: R <= {32'd0, prod[31:0]};
            default: ;
        endcase
        case (mux_D)
            MUX_D_B:     D <= {1'b0, b_in, 31'd0};
            MUX_D_B_NEG: D <= {1'b0, -b_in, 31'd0};
            MUX_D_SHR:   D <= D >> 1;
            default: ;
        endcase
        case (mux_Z)
            MUX_Z_ZERO:       Z <= 32'd0;
            MUX_Z_SHL_ADD:    Z <= {Z[30:0], ~sub_neg};
            MUX_Z_MULT_UPPER: Z <= prod[63:32];
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RV32M architectural result
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      p;
        logic [63:0] pu;
        sa = a;
        sb = b;
        case (f3)
            F3_MUL:    begin pu = {32'd0, a} * {32'd0, b}; return pu[31:0]; end
            F3_MULH:   begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            F3_MULHSU: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
            F3_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            F3_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            F3_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default:   return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_illegal"}, illegal, 0);
        chk({tag, "_res"}, {res_sel, res_neg, mult_signed_a, mult_signed_b}, 0);
        chk({tag, "_mux"}, {mux_R, mux_D, mux_Z}, {MUX_R_KEEP, MUX_D_KEEP, MUX_Z_KEEP});
    endtask

    // Issue one op at the next falling edge; optionally pulse start while it is in flight
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit poke);
        int          cyc;
        int          lat;
        logic [31:0] res;
        bit          sgn;
        lat = !f3[2] ? 2 : (DIV_EN ? ITER + 2 : 1);
        sgn = f3[2] && !f3[0];
        @(negedge clk);
        chk("idle_ready", ready, 1);
        chk("idle_busy", busy, 0);
        funct3 = f3; a_in = a; b_in = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        if (!f3[2]) begin
            chk("mul_muxes", {mux_R, mux_D, mux_Z}, {MUX_R_MULT_LOWER, MUX_D_KEEP, MUX_Z_MULT_UPPER});
            chk("mul_sign_a", mult_signed_a, (f3 == F3_MULH) || (f3 == F3_MULHSU));
            chk("mul_sign_b", mult_signed_b, f3 == F3_MULH);
        end else if (DIV_EN) begin
            chk("load_muxes", {mux_R, mux_D, mux_Z},
                {(sgn && a[31]) ? MUX_R_A_NEG : MUX_R_A, (sgn && b[31]) ? MUX_D_B_NEG : MUX_D_B, MUX_Z_ZERO});
        end else begin
            chk("illegal_muxes", {mux_R, mux_D, mux_Z}, {MUX_R_KEEP, MUX_D_KEEP, MUX_Z_KEEP});
        end
        while (!done && cyc < lat + 8) begin
            if (poke && (cyc == 1 || cyc == 10)) begin
                start = 1'b1;
                funct3 = 3'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("latency", cyc, lat);
        if (done) begin
            chk("ready_in_done", ready, 0);
            chk("illegal_flag", illegal, f3[2] && !DIV_EN);
            if (!(f3[2] && !DIV_EN)) begin
                res = res_sel ? Z : R[31:0];
                if (res_neg) res = -res;
                chk("result", res, ref_op(f3, a, b));
            end
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        resetn = 1'b0; start = 1'b0; funct3 = 3'd0; a_in = 32'd0; b_in = 32'd0;
        #1;
        chk_reset_outputs("reset");
        chk("reset_state", dut.state_q, ST_IDLE);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_no_done", {done, ready}, 2'b01);
        end

        // directed cases
        run_op(F3_MULHSU, 32'hFFFF_FFF9, 32'd3, 1'b0);
        run_op(F3_DIV,    32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(F3_REM,    32'd7,         32'd0, 1'b1);
        run_op(F3_DIV,    32'hFFFF_FFFB, 32'd0, 1'b0);
        run_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(F3_REMU,   32'd100,       32'd7, 1'b0);
        run_op(F3_MUL,    32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        run_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(F3_DIVU,   32'hFFFF_FFFF, 32'd3, 1'b0);

        // asynchronous reset in the middle of an op
        @(negedge clk);
        funct3 = F3_DIV; a_in = 32'd1000; b_in = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (DIV_EN) repeat (22) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk_reset_outputs("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_abort_idle", {done, busy, ready}, 3'b001);
        end

        // randomized ops
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), rand_operand(), rand_operand(), bit'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
